// File: rtl/noc_params.sv
// Shared NoC parameters: mesh geometry, port count and the output-port encoding.
// Also carries the round-robin index helper used by the route-computation scheduler.
package noc_params;

    localparam int MESH_SIZE_X      = 5;
    localparam int MESH_SIZE_Y      = 5;
    localparam int PORT_NUM         = 5;
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int PORT_ID_W        = $clog2(PORT_NUM);

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_type;

    // (ptr + offset) mod PORT_NUM, with offset limited to [0, PORT_NUM).
    function automatic logic [PORT_ID_W-1:0] rr_index(input logic [PORT_ID_W-1:0] ptr,
                                                     input int offset);
        int sum;
        sum = int'(ptr) + offset;
        if (sum >= PORT_NUM) begin
            sum = sum - PORT_NUM;
        end
        return PORT_ID_W'(sum);
    endfunction

endpackage

// File: rtl/rc_unit.sv
// Combinational XY route computation: resolve X first, then Y, else deliver locally.
// Smaller y is treated as NORTH; no bounds checking is done on the destination.
module rc_unit
    import noc_params::*;
#(
    parameter int X_CURRENT = 2,
    parameter int Y_CURRENT = 2
) (
    input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
    output port_type                    out_port_o
);

    always_comb begin
        out_port_o = LOCAL;
        if (int'(x_dest_i) < X_CURRENT) begin
            out_port_o = WEST;
        end else if (int'(x_dest_i) > X_CURRENT) begin
            out_port_o = EAST;
        end else if (int'(y_dest_i) < Y_CURRENT) begin
            out_port_o = NORTH;
        end else if (int'(y_dest_i) > Y_CURRENT) begin
            out_port_o = SOUTH;
        end
    end

endmodule

// File: rtl/rc_scheduler.sv
// Shares one rc_unit among PORT_NUM requesters with round-robin arbitration (IDLE/COMPUTE).
// Optional per-port completion counters are built when RC_SCHED_STATS_EN is defined.
module rc_scheduler
    import noc_params::*;
#(
    parameter int X_CURRENT = 2,
    parameter int Y_CURRENT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORT_NUM-1:0]         req_i,
    input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i [PORT_NUM],
    input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i [PORT_NUM],
    output logic [PORT_NUM-1:0]         valid_o,
    output port_type                    out_port_o [PORT_NUM],
    output logic                        busy_o
`ifdef RC_SCHED_STATS_EN
    ,
    output logic [15:0]                 grant_cnt_o [PORT_NUM]
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [PORT_ID_W-1:0]        r_rr_ptr;
    logic [PORT_ID_W-1:0]        r_id;
    logic [DEST_ADDR_SIZE_X-1:0] r_x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] r_y_dest;
    logic [PORT_NUM-1:0]         w_eligible;
    logic                        w_win_found;
    logic [PORT_ID_W-1:0]        w_win_id;
    logic                        w_grant;
    logic                        w_complete;
    port_type                    w_route;

    // A port that already holds a result is not re-served until the requester drops req_i.
    assign w_eligible = req_i & ~valid_o;
    assign w_grant    = (r_state == IDLE) && w_win_found;
    assign w_complete = (r_state == COMPUTE);
    assign busy_o     = (r_state == COMPUTE);

    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (!w_win_found && w_eligible[rr_index(r_rr_ptr, i)]) begin
                w_win_found = 1'b1;
                w_win_id    = rr_index(r_rr_ptr, i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_win_found) w_state_next = COMPUTE;
            COMPUTE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_x_dest <= '0;
            r_y_dest <= '0;
        end else begin
            if (w_grant) begin
                r_id     <= w_win_id;
                r_x_dest <= x_dest_i[w_win_id];
                r_y_dest <= y_dest_i[w_win_id];
            end
            if (w_complete) begin
                r_rr_ptr <= rr_index(r_id, 1);
            end
        end
    end

    rc_unit #(
        .X_CURRENT (X_CURRENT),
        .Y_CURRENT (Y_CURRENT)
    ) u_rc_unit (
        .x_dest_i   (r_x_dest),
        .y_dest_i   (r_y_dest),
        .out_port_o (w_route)
    );

    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_port
            logic     w_write;
            logic     r_valid;
            port_type r_out_port;

            assign w_write = w_complete && (r_id == PORT_ID_W'(gi));

            // The completion write wins over a dropped req_i; the clear follows one edge later.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid    <= 1'b0;
                    r_out_port <= LOCAL;
                end else if (w_write) begin
                    r_valid    <= 1'b1;
                    r_out_port <= w_route;
                end else if (!req_i[gi]) begin
                    r_valid    <= 1'b0;
                end
            end

            assign valid_o[gi]    = r_valid;
            assign out_port_o[gi] = r_out_port;

`ifdef RC_SCHED_STATS_EN
            logic [15:0] r_grant_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_grant_cnt <= '0;
                end else if (w_write && (r_grant_cnt != 16'hFFFF)) begin
                    r_grant_cnt <= r_grant_cnt + 16'd1;
                end
            end

            assign grant_cnt_o[gi] = r_grant_cnt;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_rc_scheduler.sv
// Directed bench for rc_scheduler at router (2,2) in a 5x5 mesh.
// Counter checks are included when RC_SCHED_STATS_EN is defined.
module tb_rc_scheduler;
    import noc_params::*;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic [PORT_NUM-1:0]         req_i;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest_i [PORT_NUM];
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i [PORT_NUM];
    logic [PORT_NUM-1:0]         valid_o;
    port_type                    out_port_o [PORT_NUM];
    logic                        busy_o;
`ifdef RC_SCHED_STATS_EN
    logic [15:0]                 grant_cnt_o [PORT_NUM];
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    rc_scheduler #(
        .X_CURRENT (2),
        .Y_CURRENT (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .x_dest_i   (x_dest_i),
        .y_dest_i   (y_dest_i),
        .valid_o    (valid_o),
        .out_port_o (out_port_o),
        .busy_o     (busy_o)
`ifdef RC_SCHED_STATS_EN
        ,
        .grant_cnt_o(grant_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dest(input int p, input int x, input int y);
        x_dest_i[p] = DEST_ADDR_SIZE_X'(x);
        y_dest_i[p] = DEST_ADDR_SIZE_Y'(y);
    endtask

    port_type exp_route [PORT_NUM];

    initial begin
        req_i = '0;
        for (int p = 0; p < PORT_NUM; p++) set_dest(p, 0, 0);

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        for (int p = 0; p < PORT_NUM; p++) check($sformatf("rst_out%0d", p), 32'(out_port_o[p]), 32'(LOCAL));

        // Single request on port 1, arbitrated on the first edge after release
        rst = 1'b1;
        set_dest(1, 4, 0);
        req_i[1] = 1'b1;
        tick();
        check("single_busy_e1", 32'(busy_o), 32'h1);
        check("single_valid_e1", 32'(valid_o), 32'h0);
        tick();
        check("single_valid_e2", 32'(valid_o), 32'b00010);
        check("single_out", 32'(out_port_o[1]), 32'(EAST));
        check("single_busy_e2", 32'(busy_o), 32'h0);
        req_i[1] = 1'b0;
        tick();
        check("single_clear", 32'(valid_o), 32'h0);
        $display("single: port1 dest(4,0) done");

        // Contention with rr_ptr back at 0
        rst = 1'b0;
        #1;
        rst = 1'b1;
        set_dest(0, 0, 4); exp_route[0] = WEST;
        set_dest(1, 2, 2); exp_route[1] = LOCAL;
        set_dest(2, 4, 1); exp_route[2] = EAST;
        set_dest(3, 0, 0); exp_route[3] = WEST;
        set_dest(4, 3, 3); exp_route[4] = EAST;
        req_i = '1;
        for (int k = 0; k < PORT_NUM; k++) begin
            tick();
            check($sformatf("cont_busy%0d", k), 32'(busy_o), 32'h1);
            check($sformatf("cont_pre%0d", k), 32'(valid_o), (32'h1 << k) - 32'h1);
            tick();
            check($sformatf("cont_valid%0d", k), 32'(valid_o), (32'h1 << (k + 1)) - 32'h1);
            check($sformatf("cont_out%0d", k), 32'(out_port_o[k]), 32'(exp_route[k]));
            $display("contention: port%0d completed out=%0d", k, out_port_o[k]);
        end
        tick();
        check("cont_hold_busy", 32'(busy_o), 32'h0);
        req_i = '0;
        tick();
        check("cont_clear", 32'(valid_o), 32'h0);

        // Fairness: port 2 served alone, then ports 0 and 2 compete -> 0 first
        set_dest(2, 2, 4);
        req_i[2] = 1'b1;
        tick(); tick();
        check("fair_p2_alone", 32'(valid_o), 32'b00100);
        check("fair_p2_out", 32'(out_port_o[2]), 32'(SOUTH));
        req_i[2] = 1'b0;
        tick();
        set_dest(0, 2, 0);
        req_i[0] = 1'b1;
        req_i[2] = 1'b1;
        tick(); tick();
        check("fair_first_p0", 32'(valid_o), 32'b00001);
        check("fair_p0_out", 32'(out_port_o[0]), 32'(NORTH));
        tick(); tick();
        check("fair_then_p2", 32'(valid_o), 32'b00101);
        req_i = '0;
        tick();
        $display("fairness: port0 before port2 after port2 served");

        // Fairness: after port 0 served, ports 0 and 2 compete -> 2 first
        req_i[0] = 1'b1;
        tick(); tick();
        check("fair2_p0_alone", 32'(valid_o), 32'b00001);
        req_i[0] = 1'b0;
        tick();
        req_i[0] = 1'b1;
        req_i[2] = 1'b1;
        tick(); tick();
        check("fair2_first_p2", 32'(valid_o), 32'b00100);
        tick(); tick();
        check("fair2_then_p0", 32'(valid_o), 32'b00101);
        req_i = '0;
        tick();
        $display("fairness: port2 before port0 after port0 served");

        // Hold then clear on port 3, re-raised in the clearing cycle
        set_dest(3, 1, 2);
        req_i[3] = 1'b1;
        tick(); tick();
        check("hold_valid", 32'(valid_o), 32'b01000);
        check("hold_out", 32'(out_port_o[3]), 32'(WEST));
        tick(); tick(); tick();
        check("hold_still", 32'(valid_o), 32'b01000);
        check("hold_no_busy", 32'(busy_o), 32'h0);
        check("hold_out_still", 32'(out_port_o[3]), 32'(WEST));
        req_i[3] = 1'b0;
        tick();
        check("hold_clear", 32'(valid_o), 32'h0);
        set_dest(3, 2, 2);
        req_i[3] = 1'b1;
        tick();
        check("rereq_e1", 32'(valid_o), 32'h0);
        tick();
        check("rereq_valid", 32'(valid_o), 32'b01000);
        check("rereq_out", 32'(out_port_o[3]), 32'(LOCAL));
        req_i[3] = 1'b0;
        tick();
        $display("hold/clear: port3 WEST held, re-request LOCAL");

        // req_i dropped during COMPUTE: result still written, cleared next edge
        set_dest(4, 3, 2);
        req_i[4] = 1'b1;
        tick();
        check("drop_busy", 32'(busy_o), 32'h1);
        req_i[4] = 1'b0;
        tick();
        check("drop_written", 32'(valid_o), 32'b10000);
        check("drop_out", 32'(out_port_o[4]), 32'(EAST));
        tick();
        check("drop_cleared", 32'(valid_o), 32'h0);
        $display("drop-in-compute: port4 EAST written then cleared");

        // Asynchronous reset during COMPUTE
        set_dest(1, 0, 0);
        req_i[1] = 1'b1;
        tick();
        check("rstmid_busy", 32'(busy_o), 32'h1);
        rst = 1'b0;
        #1;
        check("rstmid_valid", 32'(valid_o), 32'h0);
        check("rstmid_busy0", 32'(busy_o), 32'h0);
        check("rstmid_out4", 32'(out_port_o[4]), 32'(LOCAL));
        req_i[1] = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstmid_late%0d", k), {31'b0, busy_o} | 32'(valid_o), 32'h0);
        end
        $display("reset mid-op: computation discarded");

`ifdef RC_SCHED_STATS_EN
        set_dest(4, 3, 3);
        for (int k = 0; k < 3; k++) begin
            req_i[4] = 1'b1;
            tick(); tick();
            req_i[4] = 1'b0;
            tick();
        end
        for (int p = 0; p < PORT_NUM; p++)
            check($sformatf("stats_cnt%0d", p), 32'(grant_cnt_o[p]), (p == 4) ? 32'd3 : 32'd0);
        $display("stats: port4 count=%0d", grant_cnt_o[4]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rc_scheduler.md
RC_SCHEDULER -- requirements
Module: rc_scheduler

Interface
REQ-001 Parameter X_CURRENT, default 2, router x coordinate passed to the route-computation unit.
REQ-002 Parameter Y_CURRENT, default 2, router y coordinate passed to the route-computation unit.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  PORT_NUM  per-input-port request for route computation of a head flit.
REQ-006 x_dest_i  input  PORT_NUM x DEST_ADDR_SIZE_X  per-port destination x.
REQ-007 y_dest_i  input  PORT_NUM x DEST_ADDR_SIZE_Y  per-port destination y.
REQ-008 valid_o  output  PORT_NUM  per-port result-valid flag.
REQ-009 out_port_o  output  PORT_NUM x port_type  per-port computed output port.
REQ-010 busy_o  output  1  high while a computation is in flight.

Function
REQ-011 The block SHALL share one route-computation unit among PORT_NUM requesters, granting one request at a time.
REQ-012 FSM states: IDLE, COMPUTE.
REQ-013 In IDLE, eligible requesters are those with req_i=1 and valid_o=0; with none eligible, stay IDLE.
REQ-014 In IDLE with any eligible requester, select the winner by round-robin starting at rr_ptr, latch its id and destination, go to COMPUTE.
REQ-015 In COMPUTE, feed latched destination to the route unit, write its result to out_port_o[id], set valid_o[id], set rr_ptr to id+1 modulo PORT_NUM, return to IDLE.
REQ-016 Latency: valid_o rises exactly 2 rising edges after req_i is sampled high with no contention.
REQ-017 Throughput: at most one completion per 2 cycles; N simultaneous requesters complete within 2N cycles.
REQ-018 valid_o[p] and out_port_o[p] SHALL hold until req_i[p] is sampled low; then valid_o[p] clears on that edge.
REQ-019 Requester SHALL hold req_i and destination stable until valid_o; a req_i drop during COMPUTE SHALL NOT abort; result is written, then cleared at the next edge with req_i low.
REQ-020 A req_i[p] re-asserted in the same cycle valid_o[p] clears SHALL be treated as a new request.
REQ-021 busy_o = (state == COMPUTE).
REQ-022 Destinations outside the mesh SHALL be routed exactly as the route unit computes; no checking here.

Reset
REQ-023 On rst low: state=IDLE, rr_ptr=0, valid_o=0, out_port_o all LOCAL, busy_o=0, latched id/destination=0.
REQ-024 Reset asserted during COMPUTE SHALL discard the in-flight computation; no valid_o pulse after release.
REQ-025 First arbitration SHALL occur on the first rising edge with rst high.

Configuration
REQ-026 Macro RC_SCHED_STATS_EN: when defined, add output grant_cnt_o (PORT_NUM x 16), per-port count of completions, saturating at 16'hFFFF, reset to 0.
REQ-027 Without RC_SCHED_STATS_EN the port and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 PORT_NUM, DEST_ADDR_SIZE_X, DEST_ADDR_SIZE_Y, port_type SHALL come from noc_params; no local redefinition.
REQ-029 FSM state enum SHALL be local to the module.
REQ-030 The existing rc_unit SHALL be instantiated once as sub-module, parameterised with X_CURRENT/Y_CURRENT; round-robin logic stays inline.

Verification (X_CURRENT=2, Y_CURRENT=2, 5x5 mesh)
REQ-031 Single: req_i[1]=1, dest (4,0) -> valid_o[1]=1 after 2 edges, out_port_o[1]=EAST, busy_o high 1 cycle.
REQ-032 Contention: req_i all high at t0, rr_ptr=0, dests (0,4),(2,2),(4,1),(0,0),(3,3) -> completion order ports 0..4 at edges 2,4,6,8,10; results WEST,LOCAL,EAST,WEST,EAST.
REQ-033 Fairness: after port 2 served, ports 2 and 0 request -> port 0 served before port 2.
REQ-034 Hold/clear: valid_o[3] high, req_i[3] dropped -> valid_o[3]=0 next edge; re-raised with dest (2,2) -> LOCAL after 2 edges.
REQ-035 Reset mid-op: rst low during COMPUTE -> valid_o=0, state IDLE, no late valid after release.
REQ-036 Stats (RC_SCHED_STATS_EN): 3 completions on port 4 -> grant_cnt_o[4]=3, others 0.
